// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 keyboard constants, FSM encoding and helpers        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    localparam int PS2_EVT_W = 10;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE    = 2'd0;
    localparam ps2_state_t ST_EXT     = 2'd1;
    localparam ps2_state_t ST_BRK     = 2'd2;
    localparam ps2_state_t ST_EXT_BRK = 2'd3;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_event_fifo : show-ahead FIFO with push/pop/full/empty/count           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PS2_EVT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_pop;
    logic             w_push;

    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_kbd_ctrl : merges E0/F0 prefixes with scan codes into buffered events |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       rx_en,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    input  logic       key_ready,
    output logic       err_timeout,
    output logic       err_ovf
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  C_TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t             state_q, state_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   rx_en_q;
    logic                   err_timeout_q;
    logic                   err_ovf_q;

    logic                   w_ext;
    logic                   w_brk;
    logic                   w_push_req;
    logic                   w_err_byte;
    logic                   w_timeout;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_drop;
    logic [CNT_W-1:0]       w_cnt_next;

    logic [PS2_EVT_W-1:0]   fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    // State register and timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= '0;
            rx_en_q       <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            rx_en_q       <= (w_cnt_next < C_DEPTH);
            err_timeout_q <= w_timeout;
            err_ovf_q     <= w_err_byte | w_drop;
        end
    end

    // Next-state logic; a byte arriving on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            if (rx_dout == PS2_EXT) begin
                state_d = ST_EXT;
            end else if (rx_dout == PS2_BRK) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end else if (w_timeout) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        w_ext      = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        w_brk      = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        w_err_byte = rx_done_tick & is_err_byte(rx_dout);
        w_push_req = rx_done_tick & (rx_dout != PS2_EXT) & (rx_dout != PS2_BRK)
                     & ~is_err_byte(rx_dout);
        w_timeout  = (state_q != ST_IDLE) & ~rx_done_tick & (to_cnt_q == C_TO_MAX);
    end

    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rx_done_tick || (state_q == ST_IDLE) || w_timeout) begin
            to_cnt_d = '0;
        end
    end

    assign w_pop      = key_valid & key_ready;
    assign w_push_ok  = w_push_req & (~fifo_full | w_pop);
    assign w_drop     = w_push_req & ~w_push_ok;
    assign w_cnt_next = fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push_ok),
        .data_i  ({w_ext, w_brk, rx_dout}),
        .pop_i   (w_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Unused FIFO storage is masked so outputs read zero when nothing is queued.
    assign key_valid   = ~fifo_empty;
    assign key_ext     = key_valid & fifo_data[9];
    assign key_brk     = key_valid & fifo_data[8];
    assign key_code    = key_valid ? fifo_data[7:0] : 8'h00;
    assign rx_en       = rx_en_q;
    assign err_timeout = err_timeout_q;
    assign err_ovf     = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_kbd_ctrl : scoreboard bench with directed and random byte streams |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

    localparam int D = 4;
    localparam int T = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       key_ready;
    logic       rx_en;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       err_timeout;
    logic       err_ovf;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH     (D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_brk      (key_brk),
        .key_ready    (key_ready),
        .err_timeout  (err_timeout),
        .err_ovf      (err_ovf)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] q[$];
    bit         mon_on  = 0;
    bit         m_rst   = 1;
    bit         exp_ovf = 0;
    bit         exp_to  = 0;
    bit         pend    = 0;
    bit         m_ext   = 0;
    bit         m_brk   = 0;
    int         cyc     = 0;
    int         last    = 0;

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: prefix flags accumulate until a code byte; a pending
    // prefix expires when T clock edges pass without a byte.
    function automatic void model(input bit t, input logic [7:0] b, input bit r);
        exp_ovf = 0;
        exp_to  = 0;
        m_rst   = r;
        if (r) begin
            q.delete();
            pend = 0; m_ext = 0; m_brk = 0;
            return;
        end
        if (t) begin
            last = cyc;
            if (b == 8'hE0) begin
                m_ext = 1; m_brk = 0; pend = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1; pend = 1;
            end else begin
                if (b == 8'h00 || b == 8'hFF) exp_ovf = 1;
                else if (q.size() < D)        q.push_back({m_ext, m_brk, b});
                else                          exp_ovf = 1;
                pend = 0; m_ext = 0; m_brk = 0;
            end
        end else if (pend && (cyc - last) == T) begin
            exp_to = 1;
            pend = 0; m_ext = 0; m_brk = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            check("key_valid",   10'(key_valid),   10'(q.size() > 0));
            check("rx_en",       10'(rx_en),       10'(!m_rst && q.size() < D));
            check("err_ovf",     10'(err_ovf),     10'(exp_ovf));
            check("err_timeout", 10'(err_timeout), 10'(exp_to));
            if (q.size() > 0) begin
                check("event", {key_ext, key_brk, key_code}, q[0]);
                if (key_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input bit t, input logic [7:0] b, input bit r);
        rx_done_tick = t;
        rx_dout      = b;
        reset        = r;
        @(posedge clk);
        cyc++;
        model(t, b, r);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    initial begin
        int         r;
        int         k;
        logic [7:0] b;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_dout      = 8'h00;
        key_ready    = 1'b0;

        step(1'b0, 8'h00, 1'b1);
        mon_on = 1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(2);

        key_ready = 1'b1;
        send(8'h1C); idle(3);

        send(8'hE0); idle(2); send(8'hF0); idle(1); send(8'h75); idle(3);

        key_ready = 1'b0;
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); idle(2);
        send(8'h3C); idle(2);
        key_ready = 1'b1;
        idle(6);

        send(8'hF0); idle(T + 2); send(8'h1C); idle(3);
        send(8'hF0); idle(T - 1); send(8'h1C); idle(3);
        send(8'hE0); idle(T - 2); send(8'hE0); idle(T - 1); send(8'h6B); idle(3);

        send(8'hE0); send(8'hFF); idle(2);
        key_ready = 1'b0;
        send(8'h16); send(8'h1E); idle(1);
        step(1'b0, 8'h00, 1'b1);
        idle(2);

        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        key_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        idle(8);

        for (int i = 0; i < 2500; i++) begin
            key_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                idle($urandom_range(T - 3, T + 3));
            end else if (r == 2) begin
                step(1'b0, 8'h00, 1'b1);
            end else if (r < 40) begin
                k = $urandom_range(0, 9);
                case (k)
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    4:       b = 8'h00;
                    5:       b = 8'hFF;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                send(b);
            end else begin
                idle(1);
            end
        end

        key_ready = 1'b1;
        idle(10);
        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Sequencer and scan-code assembler behind the PS/2 byte receiver. It gates the receiver's `rx_en`, merges the `E0` (extended) and `F0` (break) prefix bytes with the following code byte into one key event, and buffers events in a small FIFO for the consumer. It sits between the PS/2 receiver and the keyboard-command logic, and reports timeouts and overflow.

## Interface
- `FIFO_DEPTH`, 4: event FIFO depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: maximum idle gap allowed inside a prefixed sequence, in `clk` cycles.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_done_tick` in 1: one-cycle pulse from the receiver when a byte is complete.
- `rx_dout` in 8: received byte; valid in the `rx_done_tick` cycle.
- `rx_en` out 1: enables the receiver to start a new frame.
- `key_valid` out 1: FIFO head holds an event.
- `key_code` out 8: scan code of the head event.
- `key_ext` out 1: head event was preceded by `E0`.
- `key_brk` out 1: head event was preceded by `F0` (key release).
- `key_ready` in 1: consumer accepts the head event; pop occurs when `key_valid & key_ready`.
- `err_timeout` out 1: one-cycle pulse when a partial sequence is discarded.
- `err_ovf` out 1: one-cycle pulse when an event is dropped because the FIFO is full, or when an error byte `00`/`FF` is received.

## Operation
- FSM states:
  - `IDLE`: no prefix pending.
  - `EXT`: `E0` seen.
  - `BRK`: `F0` seen.
  - `EXT_BRK`: `E0` then `F0` seen.
- Transitions apply only on `rx_done_tick`. Each received byte is handled as follows:
  - `E0` in `IDLE`: go to `EXT`.
  - `E0` in any other state: restart at `EXT`, clearing the break flag.
  - `F0` in `IDLE`: go to `BRK`.
  - `F0` in `EXT`: go to `EXT_BRK`.
  - `F0` in `BRK` or `EXT_BRK`: no change.
  - `00` or `FF`: pulse `err_ovf`, go to `IDLE`, push nothing.
  - Any other byte: push {ext, brk, byte} according to the current state, then go to `IDLE`.
- Timeout counter:
  - Width is clog2(`TIMEOUT_CYCLES`).
  - Clears on every `rx_done_tick` and while in `IDLE`.
  - Increments in all other states.
  - When it reaches `TIMEOUT_CYCLES-1`: go to `IDLE`, pulse `err_timeout`, clear the counter.
  - A byte arriving in the same cycle wins: it is processed and the timeout does not fire.
- FIFO:
  - Show-ahead, 10-bit entries {ext, brk, code[7:0]}, count width clog2(`FIFO_DEPTH`)+1.
  - A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped, `err_ovf` pulses, and the FSM still returns to `IDLE`.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous push and pop leaves count unchanged.
- `rx_en` is registered and equals (count_next < `FIFO_DEPTH`). No new frame is started while the FIFO is full; prefix bytes never push.

## Timing
- Reset values: state `IDLE`, counter 0, FIFO empty, all outputs 0. `rx_en` rises on the first cycle after `reset` deasserts.
- Assertion of `reset` mid-sequence or mid-FIFO discards everything in the next cycle.
- Latency from the final byte's `rx_done_tick` (cycle N) to the event appearing on `key_*`:
  - FIFO empty: `key_valid` is high at N+1.
  - FIFO non-empty: the event appears when it reaches the head.
- `key_*` outputs are stable while `key_valid & ~key_ready`. After a pop, the next entry is presented in the following cycle.
- `err_*` are single-cycle registered pulses, asserted at N+1 for a byte event at N.
- `rx_en` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees a slot.

## Structure
- Shared package `ps2_pkg` holds:
  - FSM state encoding (2 bits).
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF.
  - Event width `PS2_EVT_W`=10.
- One sub-module, `ps2_event_fifo`: parameterised depth, show-ahead, push/pop/full/empty/count. It is reused later by the host-to-device command path.
- The FSM and timeout counter live in `ps2_kbd_ctrl`.

## Test plan
- Make: bytes `1C` with `key_ready`=1 → one event {ext=0, brk=0, code=1C}, `key_valid` high at N+1.
- Extended break: bytes `E0`,`F0`,`75` → single event {1,1,75}; no events are emitted for the prefixes.
- Fill and stall: `key_ready`=0, 4 make codes (`15`,`1D`,`24`,`2D`) → `rx_en`=0 after the 4th. A 5th forced `rx_done_tick` with `3C` → `err_ovf` pulse. Raise `key_ready` → events pop in order, and `rx_en` returns to 1 after the first pop.
- Timeout: `F0`, then no byte for `TIMEOUT_CYCLES` → `err_timeout` pulse. A following `1C` yields {0,0,1C}, not a break.
- Error byte and reset: `E0`, then `FF` → `err_ovf`, state `IDLE`. Assert `reset` with 2 queued events → `key_valid`=0 and `rx_en`=0 the next cycle.
- Simultaneous push/pop at full (depth 4) with `key_ready`=1 → count stays 4, no `err_ovf`, order preserved across pointer wrap.
